// File: rtl/team_06_audio_pkg.sv
// rtl/team_06_audio_pkg.sv - shared types and helpers for the team_06 audio transmit path
package team_06_audio_pkg;

    typedef enum logic {
        I2S_MODE = 1'b0,
        TDM_MODE = 1'b1
    } i2s_mode_e;

    localparam int UNDERRUN_CNT_W = 8;

    // Two channels run as classic left/right I2S; anything wider is TDM with a frame-sync pulse.
    function automatic i2s_mode_e mode_of(input int num_ch);
        return (num_ch == 2) ? I2S_MODE : TDM_MODE;
    endfunction

endpackage

// File: rtl/team_06_frame_fifo.sv
// rtl/team_06_frame_fifo.sv - frame FIFO with wrap-bit pointers and a combinational head
module team_06_frame_fifo
    import team_06_audio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: emptiness is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/team_06_i2s_tx.sv
// rtl/team_06_i2s_tx.sv - multi-channel I2S/TDM DAC transmitter with frame FIFO
// TEAM06_I2S_TX_HOLD_EN: on underrun retransmit the previous frame instead of silence.
module team_06_i2s_tx
    import team_06_audio_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                              hwclk,
    input  logic                              reset,
    input  logic                              en,
    input  logic [NUM_CH*SAMPLE_W-1:0]        sample_in,
    input  logic                              sample_valid,
    output logic                              sample_ready,
    output logic                              i2sclk,
    output logic                              word_select,
    output logic                              dac_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [UNDERRUN_CNT_W-1:0]         underrun_cnt
);

    localparam int        TOTAL    = NUM_CH * SLOT_W;
    localparam int        FRAME_W  = NUM_CH * SAMPLE_W;
    localparam int        BIT_W    = $clog2(TOTAL);
    localparam int        DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam i2s_mode_e MODE     = mode_of(NUM_CH);
    localparam logic      WS_IDLE  = (MODE == TDM_MODE);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic                      i2sclk_q, i2sclk_d;
    logic                      dac_out_q, dac_out_d;
    logic                      ws_q, ws_d;
    logic [FRAME_W-1:0]        shadow_q, shadow_d;
    logic [UNDERRUN_CNT_W-1:0] urun_q, urun_d;

    logic [BIT_W-1:0]          bit_nx;
    logic [BIT_W-1:0]          ws_pos;
    logic                      fall;
    logic                      fifo_pop;
    logic                      fifo_push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FRAME_W-1:0]        fifo_head;
    logic [TOTAL-1:0]          ser_vec;

    assign fifo_push    = sample_valid && !fifo_full;
    assign sample_ready = !fifo_full;

    team_06_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (hwclk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (sample_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Frame boundary handling: pop into shadow or take the underrun path.
    always_comb begin
        bit_nx   = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        ws_pos   = (bit_nx == LAST_BIT) ? '0 : bit_nx + 1'b1;
        fall     = en && (div_cnt_q == DIV_LAST) && i2sclk_q;
        fifo_pop = 1'b0;
        shadow_d = shadow_q;
        urun_d   = urun_q;
        if (fall && (bit_nx == '0)) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shadow_d = fifo_head;
            end else begin
`ifdef TEAM06_I2S_TX_HOLD_EN
                shadow_d = shadow_q;
`else
                shadow_d = '0;
`endif
                if (urun_q != '1) begin
                    urun_d = urun_q + 1'b1;
                end
            end
        end
    end

    // Serial order: ser_vec[pos] is the bit driven at frame position pos.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar k = 0; k < SLOT_W; k++) begin : g_bit
            if (k < SAMPLE_W) begin : g_data
                assign ser_vec[c*SLOT_W + k] = shadow_d[c*SAMPLE_W + SAMPLE_W - 1 - k];
            end else begin : g_pad
                assign ser_vec[c*SLOT_W + k] = 1'b0;
            end
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        i2sclk_d  = i2sclk_q;
        bit_cnt_d = bit_cnt_q;
        dac_out_d = dac_out_q;
        ws_d      = ws_q;
        if (!en) begin
            div_cnt_d = '0;
            i2sclk_d  = 1'b0;
            bit_cnt_d = LAST_BIT;
            dac_out_d = 1'b0;
            ws_d      = WS_IDLE;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            i2sclk_d  = !i2sclk_q;
            if (fall) begin
                bit_cnt_d = bit_nx;
                dac_out_d = ser_vec[bit_nx];
                ws_d      = (MODE == I2S_MODE) ? (ws_pos >= BIT_W'(SLOT_W)) : (ws_pos == '0);
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            bit_cnt_q <= LAST_BIT;
            i2sclk_q  <= 1'b0;
            dac_out_q <= 1'b0;
            ws_q      <= WS_IDLE;
            shadow_q  <= '0;
            urun_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            i2sclk_q  <= i2sclk_d;
            dac_out_q <= dac_out_d;
            ws_q      <= ws_d;
            shadow_q  <= shadow_d;
            urun_q    <= urun_d;
        end
    end

    // Pins drop to idle as soon as en falls, without waiting for the next edge.
    assign i2sclk       = i2sclk_q && en;
    assign dac_out      = dac_out_q && en;
    assign word_select  = en ? ws_q : WS_IDLE;
    assign underrun_cnt = urun_q;

endmodule

// File: doc/team_06_i2s_tx.md
Name: team_06_i2s_tx

Overview:
Parametrised multi-channel I2S/TDM transmitter that feeds the DAC. It generalises the fixed stereo DAC path in the team_06 chip top to N channels, configurable sample and slot widths, and a frame FIFO with a valid/ready write side. It sits between the audio effect pipeline (writer) and the DAC GPIO pins (i2sclk, word_select, dac_out).

Parameters:
SAMPLE_W, 16, bits per channel sample, two's complement, sent MSB first.
SLOT_W, 16, bit clocks per channel slot; must be >= SAMPLE_W; pad bits are 0.
NUM_CH, 2, channels per frame; 2 selects I2S mode; 4 or 8 selects TDM mode.
FIFO_DEPTH, 4, frames buffered; must be a power of 2 and >= 2.
CLK_DIV, 4, hwclk cycles per i2sclk half-period; must be >= 1.

Ports:
hwclk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
en  input  1  transmit enable; low idles the serial pins.
sample_in  input  NUM_CH*SAMPLE_W  one frame; channel 0 occupies the LSBs.
sample_valid  input  1  sample_in is valid.
sample_ready  output  1  FIFO can accept a frame; equals !full.
i2sclk  output  1  serial bit clock to the DAC.
word_select  output  1  LR clock in I2S mode; frame sync in TDM mode.
dac_out  output  1  serial data to the DAC.
fifo_level  output  $clog2(FIFO_DEPTH+1)  number of frames held.
underrun_cnt  output  8  saturating count of frames sent with the FIFO empty.

Behaviour:
- Reset is asynchronous and immediate, including mid-frame:
  - i2sclk=0, dac_out=0, fifo_level=0, underrun_cnt=0, sample_ready=1.
  - word_select=0 in I2S mode, 1 in TDM mode; this is the WS idle value.
  - FIFO is emptied; the shadow frame register is cleared to 0.
  - bit_cnt=TOTAL-1, where TOTAL=NUM_CH*SLOT_W; div_cnt=0.
- Write side:
  - A push occurs when sample_valid && sample_ready on a rising hwclk edge.
  - Valid is ignored while the FIFO is full; no overwrite, no error flag.
  - fifo_level updates the cycle after the push or pop.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - i2sclk toggles on wrap, so its period is 2*CLK_DIV hwclk cycles.
- Falling-edge event, i.e. the cycle in which i2sclk goes 1->0:
  - bit_cnt' = (bit_cnt+1) mod TOTAL.
  - If bit_cnt'==0, frame load:
    - If the FIFO is non-empty, pop the head into shadow.
    - If the FIFO is empty, shadow=0 and underrun_cnt increments, saturating at 255.
  - dac_out = bit of the position bit_cnt', where slot ch=bit_cnt'/SLOT_W and offset k=bit_cnt' mod SLOT_W.
    - k < SAMPLE_W: sample bit SAMPLE_W-1-k.
    - Otherwise: 0.
  - word_select leads data by one bit. With p=(bit_cnt'+1) mod TOTAL:
    - I2S mode: word_select = (p/SLOT_W)==1, i.e. low = ch0 (left), high = ch1.
    - TDM mode: word_select = (p==0), a one-bit-wide pulse before the MSB of ch0.
- Latency: the first MSB is driven 2*CLK_DIV cycles after en rises, provided a frame is present at that edge.
- Simultaneous push and pop:
  - On a non-empty FIFO, both succeed and the level is unchanged.
  - On an empty FIFO, the pop sees empty, so the frame underruns and the pushed frame is kept.
- en=0:
  - i2sclk, dac_out and word_select are forced to their reset values.
  - div_cnt and bit_cnt return to reset values.
  - FIFO contents and underrun_cnt are held.
  - Pushes are still accepted.
- en toggling mid-frame abandons the current frame; there is no pop until the next frame boundary.

Optional Feature:
- Macro: TEAM06_I2S_TX_HOLD_EN.
- Defined: on underrun the shadow keeps the previous frame, which is retransmitted; underrun_cnt still increments.
- Undefined: underrun frames are all zeros (silence).

Decomposition:
- Package team_06_audio_pkg:
  - i2s_mode_e {I2S_MODE, TDM_MODE}.
  - Function mode_of(NUM_CH).
  - Localparam UNDERRUN_CNT_W=8.
- Sub-module team_06_frame_fifo:
  - Parametrised width and depth.
  - Registered pointers with an extra wrap bit.
  - Combinational head output, plus full/empty/level outputs.
- The top handles the divider, bit counter, shadow, serialiser and WS generation.

Test Plan:
- Defaults. Push {ch1=16'hA5A5, ch0=16'h8001}, then set en=1 -> word_select=0 while dac_out shifts 1000000000000001, then word_select=1 while it shifts 1010010110100101; first MSB at hwclk cycle 8; word_select transitions one i2sclk before each MSB.
- Empty FIFO with en=1 -> dac_out=0 for the frame and underrun_cnt increments once per 32-bit frame, saturating at 255. With TEAM06_I2S_TX_HOLD_EN, the last pushed frame repeats instead.
- Push 5 frames back-to-back with en=0 -> sample_ready drops after the 4th push and fifo_level=4. Set en=1 -> one pop per frame, and frame order is preserved.
- NUM_CH=4, SAMPLE_W=12, SLOT_W=16 -> one-bit word_select pulse during the last bit of each frame; each slot carries 12 data bits then 4 zeros.
- Assert reset mid-frame with the FIFO holding 2 frames -> outputs take reset values in the same cycle, fifo_level=0, and there is no stale data after release.
- Drop en mid-slot, then raise it again -> pins idle at once, the FIFO is unchanged, and transmission restarts cleanly at ch0 MSB.
